pipe_ctl: RTL and testbench
===========================

// Module: pipe_ctl
// PURPOSE
//  Central sequencer for the 5-stage core (IFU->IDU->EXU->LSU->WBU).
//  - Owns the per-boundary valid bits and drives the load enables of every stage register (if2id, id2ex, e2l, l2w).
//  - Resolves load-use stalls, LSU wait, branch/jump redirect flushes and the ebreak halt.
//  - Stage registers capture on ld=1 and hold on ld=0; they take their valid from this block.
// PARAMETERS
//  GPRS_W    5   GPR index width
//  ADDR_W    32  PC width
//  STALL_CW  16  stall-counter width (saturating)
// PORTS
//  i_sys_clk           in   1         core clock, all state on posedge
//  i_sys_rst_n         in   1         async active-low reset
//  i_ifu_valid         in   1         IFU presents a fetched instruction this cycle
//  i_idu_rs1_en        in   1         ID instr reads rs1
//  i_idu_rs2_en        in   1         ID instr reads rs2
//  i_idu_rs1_id        in   GPRS_W    ID rs1 index
//  i_idu_rs2_id        in   GPRS_W    ID rs2 index
//  i_exu_ld_en         in   1         EX instr is a load
//  i_exu_gpr_wr_id     in   GPRS_W    EX instr rd
//  i_exu_jmp_en        in   1         EX resolved taken branch/jump
//  i_exu_jmp_pc        in   ADDR_W    redirect target
//  i_lsu_busy          in   1         LSU memory access not complete
//  i_wbu_halt          in   1         WB instr is ebreak
//  o_pc_wr_en          out  1         PC register may advance
//  o_pc_redir_en       out  1         PC loads o_pc_redir_val instead of pc+4
//  o_pc_redir_val      out  ADDR_W    redirect target
//  o_if2id_ld          out  1         load enable, IF/ID register
//  o_id2ex_ld          out  1         load enable, ID/EX register
//  o_ex2ls_ld          out  1         load enable, EX/LS register
//  o_ls2wb_ld          out  1         load enable, LS/WB register
//  o_id_vld            out  1         valid, IF/ID
//  o_ex_vld            out  1         valid, ID/EX
//  o_ls_vld            out  1         valid, EX/LS
//  o_wb_vld            out  1         valid, LS/WB
//  o_pipe_state        out  2         registered state: 0 RUN, 1 BUBBLE, 2 WAIT, 3 HALT
//  o_stall_cnt         out  STALL_CW  cycles with o_pc_wr_en=0 outside HALT
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - All valids 0, state RUN, o_stall_cnt 0.
//  - All ld/pc_wr/redir outputs forced 0 while reset is low.
//  Control outputs are combinational from inputs + state (same-cycle). Valids and state update on posedge.
//  Per-cycle priority, highest first:
//  - HALT: state==HALT, or i_wbu_halt&&o_wb_vld.
//    - All ld=0, pc_wr=0, redir=0. Next state HALT.
//    - Sticky until reset; valids frozen.
//  - WAIT: i_lsu_busy&&o_ls_vld.
//    - All ld=0, pc_wr=0, valids hold.
//    - l2w valid cleared (bubble into WB): wb_vld<=0.
//    - A jump in EX this cycle is NOT taken yet; it is re-presented after the wait.
//  - REDIRECT: i_exu_jmp_en&&o_ex_vld.
//    - pc_wr=1, redir_en=1, redir_val=i_exu_jmp_pc.
//    - All ld=1; id_vld<=0, ex_vld<=0 (flush two wrong-path instrs).
//    - ls_vld<=1, wb_vld<=ls_vld. Overrides any load-use hazard.
//  - BUBBLE (load-use): o_ex_vld&&o_id_vld&&i_exu_ld_en&&rd!=0, and rd==rs1 with rs1_en or rd==rs2 with rs2_en.
//    - pc_wr=0, if2id_ld=0, id2ex_ld=1 with ex_vld<=0, ex2ls_ld=ls2wb_ld=1.
//    - ls_vld<=1, wb_vld<=ls_vld.
//    - One bubble only; next cycle the load is in LS and forwarding covers it.
//  - RUN:
//    - All ld=1, pc_wr=1.
//    - id_vld<=i_ifu_valid, ex_vld<=id_vld, ls_vld<=ex_vld, wb_vld<=ls_vld.
//  o_pipe_state <= code of the case taken this cycle (RUN/BUBBLE/WAIT/HALT). REDIRECT records as RUN.
//  o_stall_cnt:
//  - +1 each cycle in WAIT or BUBBLE; saturates at all-ones.
//  - Never wraps; frozen in HALT.
//  rd==0 never causes a hazard. Invalid stages never cause hazard, redirect, wait or halt.
//  Reset mid-WAIT or mid-BUBBLE: all state returns to reset values immediately, no residual stall.
// TESTING
//  - Reset then i_ifu_valid=1 for 4 cycles -> valids fill id,ex,ls,wb on cycles 1..4; all ld=1; state RUN.
//  - EX lw x5, ID add x6,x5,x1 (rs1_en=1) -> 1 cycle pc_wr=0, if2id_ld=0, ex_vld=0 next; state BUBBLE; stall_cnt 1.
//  - Same hazard with rd=x0 -> no stall, state RUN.
//  - EX jmp_en=1, pc 0x8000_0040 -> redir_en=1, redir_val=0x8000_0040; id_vld,ex_vld=0 next cycle.
//  - Jump and load-use in same cycle -> redirect only, stall_cnt unchanged.
//  - i_lsu_busy=1 for 3 cycles with ls_vld=1 -> ld all 0 for 3 cycles, wb_vld=0, stall_cnt +3, state WAIT.
//  - Then ebreak reaches WB -> state HALT, all ld=0, stays HALT.
//  - Force stall_cnt to 0xFFFF, one more BUBBLE -> stall_cnt stays 0xFFFF.
//  - rst_n low mid-WAIT -> all outputs reset asynchronously, before the next clock edge.

Source files
------------

// File: rtl/pipe_ctl.sv
// -----------------------------------------------------------------------------
// pipe_ctl : central sequencer for the 5-stage core (IFU->IDU->EXU->LSU->WBU).
//
// Owns the valid bit of every stage boundary (IF/ID, ID/EX, EX/LS, LS/WB) and
// drives the load enables of the stage registers. Each cycle it picks exactly
// one action, highest priority first: HALT (ebreak in WB, sticky), WAIT (LSU
// busy), REDIRECT (taken branch/jump in EX), BUBBLE (load-use), RUN.
//
// Ports
//   i_sys_clk, i_sys_rst_n      clock, async active-low reset
//   i_ifu_valid                 fetched instruction available
//   i_idu_rs1/2_en, _id         source operands of the ID instruction
//   i_exu_ld_en, i_exu_gpr_wr_id  EX instruction is a load / its rd
//   i_exu_jmp_en, i_exu_jmp_pc  EX resolved taken jump and its target
//   i_lsu_busy                  LSU access still in flight
//   i_wbu_halt                  WB instruction is ebreak
//   o_pc_wr_en, o_pc_redir_en, o_pc_redir_val  PC update control
//   o_*_ld                      stage-register load enables (same cycle)
//   o_*_vld                     registered stage valids
//   o_pipe_state                0 RUN, 1 BUBBLE, 2 WAIT, 3 HALT (registered)
//   o_stall_cnt                 saturating count of WAIT/BUBBLE cycles
// -----------------------------------------------------------------------------
module pipe_ctl #(
  parameter int GPRS_W   = 5,
  parameter int ADDR_W   = 32,
  parameter int STALL_CW = 16
) (
  input  logic                i_sys_clk,
  input  logic                i_sys_rst_n,
  input  logic                i_ifu_valid,
  input  logic                i_idu_rs1_en,
  input  logic                i_idu_rs2_en,
  input  logic [GPRS_W-1:0]   i_idu_rs1_id,
  input  logic [GPRS_W-1:0]   i_idu_rs2_id,
  input  logic                i_exu_ld_en,
  input  logic [GPRS_W-1:0]   i_exu_gpr_wr_id,
  input  logic                i_exu_jmp_en,
  input  logic [ADDR_W-1:0]   i_exu_jmp_pc,
  input  logic                i_lsu_busy,
  input  logic                i_wbu_halt,
  output logic                o_pc_wr_en,
  output logic                o_pc_redir_en,
  output logic [ADDR_W-1:0]   o_pc_redir_val,
  output logic                o_if2id_ld,
  output logic                o_id2ex_ld,
  output logic                o_ex2ls_ld,
  output logic                o_ls2wb_ld,
  output logic                o_id_vld,
  output logic                o_ex_vld,
  output logic                o_ls_vld,
  output logic                o_wb_vld,
  output logic [1:0]          o_pipe_state,
  output logic [STALL_CW-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                id_vld_q, id_vld_d;
  logic                ex_vld_q, ex_vld_d;
  logic                ls_vld_q, ls_vld_d;
  logic                wb_vld_q, wb_vld_d;
  logic [STALL_CW-1:0] stall_cnt_q, stall_cnt_d;

  logic halt_c, wait_c, redir_c, hazard_c;
  logic pc_wr_c, redir_en_c, if2id_c, id2ex_c, ex2ls_c, ls2wb_c;
  logic [STALL_CW-1:0] stall_inc;

  // Every condition is qualified by the valid of the stage it comes from, so
  // a bubble can never stall, redirect or halt the pipe.
  assign halt_c   = (state_q == ST_HALT) || (i_wbu_halt && wb_vld_q);
  assign wait_c   = i_lsu_busy && ls_vld_q;
  assign redir_c  = i_exu_jmp_en && ex_vld_q;
  assign hazard_c = ex_vld_q && id_vld_q && i_exu_ld_en && (i_exu_gpr_wr_id != '0) &&
                    ((i_idu_rs1_en && (i_exu_gpr_wr_id == i_idu_rs1_id)) ||
                     (i_idu_rs2_en && (i_exu_gpr_wr_id == i_idu_rs2_id)));

  assign stall_inc = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + STALL_CW'(1);

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    pc_wr_c     = 1'b0;
    redir_en_c  = 1'b0;
    if2id_c     = 1'b0;
    id2ex_c     = 1'b0;
    ex2ls_c     = 1'b0;
    ls2wb_c     = 1'b0;
    state_d     = state_q;
    id_vld_d    = id_vld_q;
    ex_vld_d    = ex_vld_q;
    ls_vld_d    = ls_vld_q;
    wb_vld_d    = wb_vld_q;
    stall_cnt_d = stall_cnt_q;

    if (halt_c) begin
      state_d = ST_HALT;
    end else if (wait_c) begin
      // Everything holds; WB gets a bubble. A jump in EX is re-presented later.
      state_d     = ST_WAIT;
      wb_vld_d    = 1'b0;
      stall_cnt_d = stall_inc;
    end else if (redir_c) begin
      // Squash the two younger wrong-path instructions in IF/ID and ID/EX.
      pc_wr_c    = 1'b1;
      redir_en_c = 1'b1;
      if2id_c    = 1'b1;
      id2ex_c    = 1'b1;
      ex2ls_c    = 1'b1;
      ls2wb_c    = 1'b1;
      state_d    = ST_RUN;
      id_vld_d   = 1'b0;
      ex_vld_d   = 1'b0;
      ls_vld_d   = 1'b1;
      wb_vld_d   = ls_vld_q;
    end else if (hazard_c) begin
      // Hold IF/ID and the PC, inject one bubble into ID/EX; after that the
      // load sits in LS and forwarding covers the dependency.
      id2ex_c     = 1'b1;
      ex2ls_c     = 1'b1;
      ls2wb_c     = 1'b1;
      state_d     = ST_BUBBLE;
      ex_vld_d    = 1'b0;
      ls_vld_d    = 1'b1;
      wb_vld_d    = ls_vld_q;
      stall_cnt_d = stall_inc;
    end else begin
      pc_wr_c  = 1'b1;
      if2id_c  = 1'b1;
      id2ex_c  = 1'b1;
      ex2ls_c  = 1'b1;
      ls2wb_c  = 1'b1;
      state_d  = ST_RUN;
      id_vld_d = i_ifu_valid;
      ex_vld_d = id_vld_q;
      ls_vld_d = ex_vld_q;
      wb_vld_d = ls_vld_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q     <= ST_RUN;
      id_vld_q    <= 1'b0;
      ex_vld_q    <= 1'b0;
      ls_vld_q    <= 1'b0;
      wb_vld_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      id_vld_q    <= id_vld_d;
      ex_vld_q    <= ex_vld_d;
      ls_vld_q    <= ls_vld_d;
      wb_vld_q    <= wb_vld_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Control outputs are combinational; gating with reset keeps the stage
  // registers and PC from moving while reset is asserted.
  assign o_pc_wr_en     = pc_wr_c    & i_sys_rst_n;
  assign o_pc_redir_en  = redir_en_c & i_sys_rst_n;
  assign o_pc_redir_val = o_pc_redir_en ? i_exu_jmp_pc : '0;
  assign o_if2id_ld     = if2id_c    & i_sys_rst_n;
  assign o_id2ex_ld     = id2ex_c    & i_sys_rst_n;
  assign o_ex2ls_ld     = ex2ls_c    & i_sys_rst_n;
  assign o_ls2wb_ld     = ls2wb_c    & i_sys_rst_n;

  assign o_id_vld     = id_vld_q;
  assign o_ex_vld     = ex_vld_q;
  assign o_ls_vld     = ls_vld_q;
  assign o_wb_vld     = wb_vld_q;
  assign o_pipe_state = state_q;
  assign o_stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctl : self-checking bench for pipe_ctl.
// Directed table of {inputs, expected outputs}, hand-written sequences for
// async reset and counter saturation, and randomized stimulus compared to a
// behavioural model of the pipeline valids, state and stall counter.
// -----------------------------------------------------------------------------
module tb_pipe_ctl;

  logic        clk;
  logic        rst_n;
  logic        ifu_valid;
  logic        rs1_en, rs2_en;
  logic [4:0]  rs1_id, rs2_id;
  logic        ld_en;
  logic [4:0]  rd_id;
  logic        jmp_en;
  logic [31:0] jmp_pc;
  logic        lsu_busy;
  logic        wbu_halt;
  logic        pc_wr_en, pc_redir_en;
  logic [31:0] pc_redir_val;
  logic        if2id_ld, id2ex_ld, ex2ls_ld, ls2wb_ld;
  logic        id_vld, ex_vld, ls_vld, wb_vld;
  logic [1:0]  pipe_state;
  logic [15:0] stall_cnt;

  pipe_ctl #(.GPRS_W(5), .ADDR_W(32), .STALL_CW(16)) dut (
    .i_sys_clk       (clk),
    .i_sys_rst_n     (rst_n),
    .i_ifu_valid     (ifu_valid),
    .i_idu_rs1_en    (rs1_en),
    .i_idu_rs2_en    (rs2_en),
    .i_idu_rs1_id    (rs1_id),
    .i_idu_rs2_id    (rs2_id),
    .i_exu_ld_en     (ld_en),
    .i_exu_gpr_wr_id (rd_id),
    .i_exu_jmp_en    (jmp_en),
    .i_exu_jmp_pc    (jmp_pc),
    .i_lsu_busy      (lsu_busy),
    .i_wbu_halt      (wbu_halt),
    .o_pc_wr_en      (pc_wr_en),
    .o_pc_redir_en   (pc_redir_en),
    .o_pc_redir_val  (pc_redir_val),
    .o_if2id_ld      (if2id_ld),
    .o_id2ex_ld      (id2ex_ld),
    .o_ex2ls_ld      (ex2ls_ld),
    .o_ls2wb_ld      (ls2wb_ld),
    .o_id_vld        (id_vld),
    .o_ex_vld        (ex_vld),
    .o_ls_vld        (ls_vld),
    .o_wb_vld        (wb_vld),
    .o_pipe_state    (pipe_state),
    .o_stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_wr, redir, if2id, id2ex, ex2ls, ls2wb} and {id, ex, ls, wb}
  wire [5:0] ctl_vec = {pc_wr_en, pc_redir_en, if2id_ld, id2ex_ld, ex2ls_ld, ls2wb_ld};
  wire [3:0] vld_vec = {id_vld, ex_vld, ls_vld, wb_vld};

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        ifu;
    logic        r1en;
    logic        r2en;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        ld;
    logic [4:0]  rd;
    logic        jmp;
    logic [31:0] jpc;
    logic        busy;
    logic        halt;
    logic [5:0]  exp_ctl;    // this cycle
    logic [3:0]  exp_vld;    // after the edge
    logic [1:0]  exp_state;  // after the edge
    logic [15:0] exp_cnt;    // after the edge
  } vec_t;

  task automatic drive(input vec_t v);
    ifu_valid = v.ifu;  rs1_en = v.r1en; rs2_en = v.r2en;
    rs1_id = v.r1;      rs2_id = v.r2;   ld_en = v.ld;
    rd_id = v.rd;       jmp_en = v.jmp;  jmp_pc = v.jpc;
    lsu_busy = v.busy;  wbu_halt = v.halt;
  endtask

  // ------------------------------------------------------ behavioural model
  localparam int K_RUN = 0, K_BUB = 1, K_WAIT = 2, K_HALT = 3, K_REDIR = 4;
  bit m_vld [4];  // 0 id, 1 ex, 2 ls, 3 wb
  int m_state;
  int m_cnt;

  function automatic int model_kind();
    bit hz;
    hz = m_vld[0] && m_vld[1] && ld_en && (rd_id != 0) &&
         ((rs1_en && rd_id == rs1_id) || (rs2_en && rd_id == rs2_id));
    if (m_state == K_HALT || (wbu_halt && m_vld[3])) return K_HALT;
    if (lsu_busy && m_vld[2])                         return K_WAIT;
    if (jmp_en && m_vld[1])                           return K_REDIR;
    if (hz)                                           return K_BUB;
    return K_RUN;
  endfunction

  function automatic logic [5:0] ctl_of(input int kind);
    case (kind)
      K_HALT, K_WAIT: return 6'b000000;
      K_REDIR:        return 6'b111111;
      K_BUB:          return 6'b000111;
      default:        return 6'b101111;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
    m_state = K_RUN;
    m_cnt   = 0;
  endtask

  task automatic model_update(input int kind);
    case (kind)
      K_HALT: m_state = K_HALT;
      K_WAIT: begin
        m_vld[3] = 1'b0;
        m_state  = K_WAIT;
        if (m_cnt < 65535) m_cnt++;
      end
      K_REDIR: begin
        m_vld[3] = m_vld[2];
        m_vld[2] = 1'b1;
        m_vld[1] = 1'b0;
        m_vld[0] = 1'b0;
        m_state  = K_RUN;
      end
      K_BUB: begin
        m_vld[3] = m_vld[2];
        m_vld[2] = 1'b1;
        m_vld[1] = 1'b0;
        m_state  = K_BUB;
        if (m_cnt < 65535) m_cnt++;
      end
      default: begin
        m_vld[3] = m_vld[2];
        m_vld[2] = m_vld[1];
        m_vld[1] = m_vld[0];
        m_vld[0] = ifu_valid;
        m_state  = K_RUN;
      end
    endcase
  endtask

  // Called #1 after a posedge with inputs already driven.
  task automatic step(input string tag);
    int          kind;
    logic [31:0] erv;
    kind = model_kind();
    erv  = (kind == K_REDIR) ? jmp_pc : 32'h0;
    #2;
    check({tag, " ctl"},   32'(ctl_vec), 32'(ctl_of(kind)));
    check({tag, " rval"},  pc_redir_val, erv);
    check({tag, " vld"},   32'(vld_vec), 32'({m_vld[0], m_vld[1], m_vld[2], m_vld[3]}));
    check({tag, " state"}, 32'(pipe_state), 32'(m_state));
    check({tag, " cnt"},   32'(stall_cnt), 32'(m_cnt));
    @(posedge clk);
    model_update(kind);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check({tag, " rst ctl"},   32'(ctl_vec), 32'h0);
    check({tag, " rst rval"},  pc_redir_val, 32'h0);
    check({tag, " rst vld"},   32'(vld_vec), 32'h0);
    check({tag, " rst state"}, 32'(pipe_state), 32'h0);
    check({tag, " rst cnt"},   32'(stall_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic idle_inputs();
    ifu_valid = 0; rs1_en = 0; rs2_en = 0; rs1_id = 0; rs2_id = 0;
    ld_en = 0; rd_id = 0; jmp_en = 0; jmp_pc = 0; lsu_busy = 0; wbu_halt = 0;
  endtask

  vec_t tbl [15];

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    ifu_valid = 1'b1;  // reset must override a would-be RUN
    jmp_en    = 1'b1;

    //           ifu r1e r2e r1 r2 ld rd jmp jpc           busy halt  ctl        vld      st  cnt
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          1, 0, 6'b101111, 4'b1000, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 1, 32'h1234,       0, 1, 6'b101111, 4'b1100, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 6'b101111, 4'b1110, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 6'b101111, 4'b1111, 0, 0};
    tbl[4]  = '{1, 1, 0, 5, 1, 1, 5, 0, 32'h0,          0, 0, 6'b000111, 4'b1011, 1, 1};
    tbl[5]  = '{1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 6'b101111, 4'b1101, 0, 1};
    tbl[6]  = '{1, 1, 0, 0, 1, 1, 0, 0, 32'h0,          0, 0, 6'b101111, 4'b1110, 0, 1};
    tbl[7]  = '{1, 0, 1, 2, 5, 1, 5, 1, 32'h8000_0040,  0, 0, 6'b111111, 4'b0011, 0, 1};
    tbl[8]  = '{1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          1, 0, 6'b000000, 4'b0010, 2, 2};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 1, 32'h44,         1, 0, 6'b000000, 4'b0010, 2, 3};
    tbl[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          1, 0, 6'b000000, 4'b0010, 2, 4};
    tbl[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 6'b101111, 4'b1001, 0, 4};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 1, 6'b000000, 4'b1001, 3, 4};
    tbl[13] = '{1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          1, 0, 6'b000000, 4'b1001, 3, 4};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 0, 1, 32'h88,         0, 0, 6'b000000, 4'b1001, 3, 4};

    do_reset("init");

    // ---- directed table
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i]);
      #2;
      check($sformatf("tbl%0d ctl", i), 32'(ctl_vec), 32'(tbl[i].exp_ctl));
      check($sformatf("tbl%0d rval", i), pc_redir_val,
            tbl[i].exp_ctl[4] ? tbl[i].jpc : 32'h0);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d vld", i),   32'(vld_vec),    32'(tbl[i].exp_vld));
      check($sformatf("tbl%0d state", i), 32'(pipe_state), 32'(tbl[i].exp_state));
      check($sformatf("tbl%0d cnt", i),   32'(stall_cnt),  32'(tbl[i].exp_cnt));
    end

    // ---- async reset in the middle of a WAIT
    do_reset("pre_wait");
    idle_inputs();
    ifu_valid = 1'b1;
    for (int i = 0; i < 3; i++) step("fill");
    lsu_busy = 1'b1;
    step("wait_a");
    step("wait_b");
    check("in_wait state", 32'(pipe_state), 32'd2);
    rst_n = 1'b0;
    #1;  // well before the next edge
    check("async rst ctl",   32'(ctl_vec), 32'h0);
    check("async rst vld",   32'(vld_vec), 32'h0);
    check("async rst state", 32'(pipe_state), 32'h0);
    check("async rst cnt",   32'(stall_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    lsu_busy = 1'b0;
    step("post_rst");

    // ---- stall counter saturation: long WAIT, then one more BUBBLE
    do_reset("pre_sat");
    idle_inputs();
    ifu_valid = 1'b1;
    for (int i = 0; i < 3; i++) step("sat_fill");
    lsu_busy = 1'b1;
    for (int i = 0; i < 65540; i++) step("sat_wait");
    check("sat after wait", 32'(stall_cnt), 32'hFFFF);
    lsu_busy = 1'b0;
    step("sat_run");
    ld_en = 1'b1; rd_id = 5'd7; rs2_en = 1'b1; rs2_id = 5'd7;
    check("sat bub state before", 32'(vld_vec), 32'hF);
    step("sat_bub");
    check("sat bub state", 32'(pipe_state), 32'd1);
    check("sat after bubble", 32'(stall_cnt), 32'hFFFF);

    // ---- randomized stimulus against the model
    do_reset("pre_rand");
    for (int i = 0; i < 4000; i++) begin
      ifu_valid = ($urandom_range(0, 9) < 8);
      rs1_en    = $urandom_range(0, 1) == 1;
      rs2_en    = $urandom_range(0, 1) == 1;
      rs1_id    = 5'($urandom_range(0, 3));
      rs2_id    = 5'($urandom_range(0, 3));
      ld_en     = $urandom_range(0, 1) == 1;
      rd_id     = 5'($urandom_range(0, 3));
      jmp_en    = ($urandom_range(0, 9) < 2);
      jmp_pc    = $urandom;
      lsu_busy  = ($urandom_range(0, 3) == 0);
      wbu_halt  = ($urandom_range(0, 49) == 0);
      step("rand");
      if ((m_state == K_HALT && $urandom_range(0, 5) == 0) || (i % 500 == 499))
        do_reset("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
